// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared state encoding, width defaults and accumulator start value; POOL_RELU_EN selects ReLU start
package pool_pkg;

  localparam int POOL_ADDR_WIDTH = 12;
  localparam int POOL_DATA_WIDTH = 16;
  localparam int POOL_DIM_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    FIN  = 3'd5,
    WR   = 3'd6,
    DONE = 3'd7
  } pool_state_t;

  // Starting value of the window maximum. Zero makes ReLU fall out of the max
  // for free; the most-negative value gives plain signed max pooling.
`ifdef POOL_RELU_EN
  localparam logic signed [POOL_DATA_WIDTH-1:0] ACC_INIT = '0;
`else
  localparam logic signed [POOL_DATA_WIDTH-1:0] ACC_INIT = {1'b1, {(POOL_DATA_WIDTH-1){1'b0}}};
`endif

endpackage

// File: rtl/pool_addr_gen.sv
// rtl/pool_addr_gen.sv - pooled-element counters, source/destination address generation and last-element flag
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int ADDR_WIDTH = POOL_ADDR_WIDTH,
  parameter int DIM_WIDTH  = POOL_DIM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  start,
  input  logic                  advance,
  input  logic [DIM_WIDTH-1:0]  cfg_rows,
  input  logic [DIM_WIDTH-1:0]  cfg_cols,
  input  logic [ADDR_WIDTH-1:0] cfg_src_base,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_base,
  input  logic [1:0]            rd_sel,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  last
);

  logic [DIM_WIDTH-1:0]  cols_q;
  logic [DIM_WIDTH-1:0]  pr_q;
  logic [DIM_WIDTH-1:0]  pc_q;
  logic [ADDR_WIDTH-1:0] src_q;
  logic [ADDR_WIDTH-1:0] dst_q;
  logic [DIM_WIDTH-1:0]  r_q;
  logic [DIM_WIDTH-1:0]  c_q;
  logic [ADDR_WIDTH-1:0] row_off_q;
  logic [ADDR_WIDTH-1:0] wr_off_q;
  logic                  col_wrap;

  assign col_wrap = (c_q == pc_q - DIM_WIDTH'(1));
  assign last     = col_wrap && (r_q == pr_q - DIM_WIDTH'(1));

  // Window top-left is src + 2r*cols + 2c; rd_sel[1] steps one source row, rd_sel[0] one column.
  assign rd_addr = src_q + row_off_q + ADDR_WIDTH'({c_q, 1'b0})
                 + (rd_sel[1] ? ADDR_WIDTH'(cols_q) : '0)
                 + ADDR_WIDTH'(rd_sel[0]);

  // Row-major pooled output is contiguous, so the element index is the offset.
  assign wr_addr = dst_q + wr_off_q;

  // Latch the geometry at start, then step c/r and keep 2r*cols by repeated addition.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cols_q    <= '0;
      pr_q      <= '0;
      pc_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      r_q       <= '0;
      c_q       <= '0;
      row_off_q <= '0;
      wr_off_q  <= '0;
    end else if (start) begin
      cols_q    <= cfg_cols;
      pr_q      <= cfg_rows >> 1;
      pc_q      <= cfg_cols >> 1;
      src_q     <= cfg_src_base;
      dst_q     <= cfg_dst_base;
      r_q       <= '0;
      c_q       <= '0;
      row_off_q <= '0;
      wr_off_q  <= '0;
    end else if (advance) begin
      wr_off_q <= wr_off_q + ADDR_WIDTH'(1);
      if (col_wrap) begin
        c_q       <= '0;
        r_q       <= r_q + DIM_WIDTH'(1);
        row_off_q <= row_off_q + ADDR_WIDTH'({cols_q, 1'b0});
      end else begin
        c_q <= c_q + DIM_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pool_relu_stage.sv
// rtl/pool_relu_stage.sv - ReLU + 2x2/2 max pooling between two SRAMs; POOL_RELU_EN enables the ReLU clamp
module pool_relu_stage
  import pool_pkg::*;
#(
  parameter int ADDR_WIDTH = POOL_ADDR_WIDTH,
  parameter int DATA_WIDTH = POOL_DATA_WIDTH,
  parameter int DIM_WIDTH  = POOL_DIM_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  pool_run,
  output logic                  pool_busy,
  input  logic [DIM_WIDTH-1:0]  cfg_rows,
  input  logic [DIM_WIDTH-1:0]  cfg_cols,
  input  logic [ADDR_WIDTH-1:0] cfg_src_base,
  input  logic [ADDR_WIDTH-1:0] cfg_dst_base,
  output logic [ADDR_WIDTH-1:0] pool_sram_read_address,
  input  logic [DATA_WIDTH-1:0] sram_pool_read_data,
  output logic                  pool_sram_write_enable,
  output logic [ADDR_WIDTH-1:0] pool_sram_write_address,
  output logic [DATA_WIDTH-1:0] pool_sram_write_data
);

  // Same start value as the package constant, rebuilt at this instance's width.
  localparam logic signed [DATA_WIDTH-1:0] ACC_START =
    ACC_INIT[POOL_DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : '0;

  pool_state_t                  state;
  pool_state_t                  state_next;
  logic signed [DATA_WIDTH-1:0] acc;
  logic signed [DATA_WIDTH-1:0] sample;
  logic signed [DATA_WIDTH-1:0] fold;
  logic                         last_q;
  logic                         start;
  logic                         advance;
  logic                         size_zero;
  logic                         rd_issue;
  logic [1:0]                   rd_sel;
  logic [ADDR_WIDTH-1:0]        ag_rd_addr;
  logic [ADDR_WIDTH-1:0]        ag_wr_addr;
  logic                         ag_last;

  assign start     = (state == IDLE) && pool_run;
  assign advance   = (state == FIN);
  assign size_zero = (cfg_rows < DIM_WIDTH'(2)) || (cfg_cols < DIM_WIDTH'(2));
  assign sample    = sram_pool_read_data;
  assign fold      = (sample > acc) ? sample : acc;
  assign rd_issue  = (state_next == RD0) || (state_next == RD1) ||
                     (state_next == RD2) || (state_next == RD3);

  pool_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .reset_b      (reset_b),
    .start        (start),
    .advance      (advance),
    .cfg_rows     (cfg_rows),
    .cfg_cols     (cfg_cols),
    .cfg_src_base (cfg_src_base),
    .cfg_dst_base (cfg_dst_base),
    .rd_sel       (rd_sel),
    .rd_addr      (ag_rd_addr),
    .wr_addr      (ag_wr_addr),
    .last         (ag_last)
  );

  // Next state, plus which of the four window reads the next state issues.
  always_comb begin
    state_next = state;
    rd_sel     = 2'd0;
    case (state)
      IDLE: if (pool_run) state_next = size_zero ? DONE : RD0;
      RD0: begin
        state_next = RD1;
        rd_sel     = 2'd1;
      end
      RD1: begin
        state_next = RD2;
        rd_sel     = 2'd2;
      end
      RD2: begin
        state_next = RD3;
        rd_sel     = 2'd3;
      end
      RD3:     state_next = FIN;
      FIN:     state_next = WR;
      WR:      state_next = last_q ? DONE : RD0;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_next;
  end

  // Window maximum: reset at RD0, folded as each sample returns one cycle after its read.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      acc    <= '0;
      last_q <= 1'b0;
    end else begin
      if (state == RD0) acc <= ACC_START;
      else if ((state == RD1) || (state == RD2) || (state == RD3)) acc <= fold;
      // Counters advance on leaving FIN, so remember whether this element was the last.
      if (state == FIN) last_q <= ag_last;
    end
  end

  // Registered SRAM-side outputs, loaded from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pool_busy               <= 1'b0;
      pool_sram_read_address  <= '0;
      pool_sram_write_enable  <= 1'b0;
      pool_sram_write_address <= '0;
      pool_sram_write_data    <= '0;
    end else begin
      pool_busy <= (state_next != IDLE);
      if (rd_issue) pool_sram_read_address <= (state == IDLE) ? cfg_src_base : ag_rd_addr;
      else          pool_sram_read_address <= '0;
      pool_sram_write_enable  <= (state == FIN);
      pool_sram_write_address <= (state == FIN) ? ag_wr_addr : '0;
      pool_sram_write_data    <= (state == FIN) ? fold : '0;
    end
  end

endmodule

// File: tb/tb_pool_relu_stage.sv
// tb/tb_pool_relu_stage.sv - scoreboard bench for pool_relu_stage (honours POOL_RELU_EN)
module tb_pool_relu_stage;

`ifdef POOL_RELU_EN
  localparam int ACC_INIT_TB = 0;
`else
  localparam int ACC_INIT_TB = -32768;
`endif

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        pool_run = 1'b0;
  logic        pool_busy;
  logic [7:0]  cfg_rows = '0;
  logic [7:0]  cfg_cols = '0;
  logic [11:0] cfg_src_base = '0;
  logic [11:0] cfg_dst_base = '0;
  logic [11:0] pool_sram_read_address;
  logic [15:0] sram_pool_read_data = '0;
  logic        pool_sram_write_enable;
  logic [11:0] pool_sram_write_address;
  logic [15:0] pool_sram_write_data;

  logic [15:0] mem [0:4095];

  int checks = 0;
  int failures = 0;
  int busy_total = 0;
  int write_total = 0;
  int rise_total = 0;
  logic busy_prev = 1'b0;

  logic [27:0] sb[$];
  logic [11:0] exp_rd[$];
  logic [11:0] rd_log[$];

  pool_relu_stage dut (
    .clk                     (clk),
    .reset_b                 (reset_b),
    .pool_run                (pool_run),
    .pool_busy               (pool_busy),
    .cfg_rows                (cfg_rows),
    .cfg_cols                (cfg_cols),
    .cfg_src_base            (cfg_src_base),
    .cfg_dst_base            (cfg_dst_base),
    .pool_sram_read_address  (pool_sram_read_address),
    .sram_pool_read_data     (sram_pool_read_data),
    .pool_sram_write_enable  (pool_sram_write_enable),
    .pool_sram_write_address (pool_sram_write_address),
    .pool_sram_write_data    (pool_sram_write_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sram_pool_read_data <= mem[pool_sram_read_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [27:0] e;
    if (pool_busy) busy_total++;
    if (pool_busy && !busy_prev) rise_total++;
    busy_prev = pool_busy;
    if (pool_sram_read_address != 12'h000) rd_log.push_back(pool_sram_read_address);
    if (pool_sram_write_enable) begin
      write_total++;
      check("write_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("write_addr", pool_sram_write_address, e[27:16]);
        check("write_data", pool_sram_write_data, e[15:0]);
      end
    end else begin
      check("idle_write_outputs", {pool_sram_write_address, pool_sram_write_data}, 0);
    end
  end

  task automatic push_model(input int rows, input int cols, input logic [11:0] src,
                            input logic [11:0] dst, input int limit);
    int pr;
    int pc;
    int n;
    int acc;
    int row;
    int col;
    logic [11:0] a;
    logic [11:0] wa;
    logic signed [15:0] s;
    pr = rows / 2;
    pc = cols / 2;
    n = 0;
    for (int r = 0; r < pr; r++) begin
      for (int c = 0; c < pc; c++) begin
        if (n < limit) begin
          acc = ACC_INIT_TB;
          for (int k = 0; k < 4; k++) begin
            row = 2 * r + k / 2;
            col = 2 * c + k % 2;
            a = src + 12'(row * cols + col);
            exp_rd.push_back(a);
            s = mem[a];
            if (int'(s) > acc) acc = int'(s);
          end
          wa = dst + 12'(r * pc + c);
          sb.push_back({wa, acc[15:0]});
          n++;
        end
      end
    end
  endtask

  task automatic start_op(input int rows, input int cols, input logic [11:0] src, input logic [11:0] dst);
    @(negedge clk);
    cfg_rows = 8'(rows);
    cfg_cols = 8'(cols);
    cfg_src_base = src;
    cfg_dst_base = dst;
    pool_run = 1'b1;
    @(posedge clk);
    #1;
    pool_run = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    logic done;
    done = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!pool_busy) begin
        done = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, done, 1);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, pool_busy, 0);
    check({tag, "_rd_addr"}, pool_sram_read_address, 0);
    check({tag, "_we"}, pool_sram_write_enable, 0);
    check({tag, "_wr_addr"}, pool_sram_write_address, 0);
    check({tag, "_wr_data"}, pool_sram_write_data, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int w0;
    int r0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset_b = 1'b1;
    @(negedge clk);

    // 8x12 ramp centred on zero
    for (int i = 0; i < 96; i++) mem[i] = 16'(i - 48);
    push_model(8, 12, 12'h000, 12'h100, 1000);
    b0 = busy_total;
    w0 = write_total;
    start_op(8, 12, 12'h000, 12'h100);
    check("t1_busy_rise", pool_busy, 1);
    wait_done("t1", 400);
    check("t1_busy_cycles", busy_total - b0, 145);
    check("t1_writes", write_total - w0, 24);
    check("t1_sb_empty", sb.size(), 0);

    // 4x4 with one all-negative window and one with a tied maximum
    begin
      int vals [16] = '{-5, -3, 1, 9, -7, -1, 2, 9, -100, -50, 3, -2, -9, -8, 4, 4};
      for (int i = 0; i < 16; i++) mem[12'h300 + i] = 16'(vals[i]);
    end
    push_model(4, 4, 12'h300, 12'h180, 1000);
    b0 = busy_total;
    w0 = write_total;
    start_op(4, 4, 12'h300, 12'h180);
    wait_done("t2", 100);
    check("t2_busy_cycles", busy_total - b0, 25);
    check("t2_writes", write_total - w0, 4);
    check("t2_sb_empty", sb.size(), 0);

    // 5x3: odd last row and column must never be read
    for (int i = 0; i < 15; i++) mem[12'h200 + i] = 16'($urandom_range(0, 65535));
    rd_log.delete();
    exp_rd.delete();
    push_model(5, 3, 12'h200, 12'h1C0, 1000);
    w0 = write_total;
    start_op(5, 3, 12'h200, 12'h1C0);
    wait_done("t3", 100);
    check("t3_writes", write_total - w0, 2);
    check("t3_read_count", rd_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < rd_log.size()) check("t3_read_addr", rd_log[i], exp_rd[i]);
    check("t3_sb_empty", sb.size(), 0);

    // zero rows: DONE only
    rd_log.delete();
    b0 = busy_total;
    w0 = write_total;
    start_op(0, 5, 12'h200, 12'h1E0);
    wait_done("t4", 20);
    check("t4_busy_cycles", busy_total - b0, 1);
    check("t4_writes", write_total - w0, 0);
    check("t4_reads", rd_log.size(), 0);

    // reset during the third element's RD2
    push_model(4, 4, 12'h300, 12'h500, 2);
    w0 = write_total;
    start_op(4, 4, 12'h300, 12'h500);
    repeat (14) @(posedge clk);
    #2;
    reset_b = 1'b0;
    #1;
    check_outputs_zero("t5_abort");
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_writes_before_abort", write_total - w0, 2);
    check("t5_sb_empty", sb.size(), 0);
    check("t5_idle_after_reset", pool_busy, 0);
    push_model(4, 4, 12'h300, 12'h500, 1000);
    b0 = busy_total;
    w0 = write_total;
    start_op(4, 4, 12'h300, 12'h500);
    wait_done("t5_rerun", 100);
    check("t5_rerun_busy", busy_total - b0, 25);
    check("t5_rerun_writes", write_total - w0, 4);
    check("t5_rerun_sb_empty", sb.size(), 0);

    // run held high and re-pulsed while busy
    push_model(4, 4, 12'h300, 12'h600, 1000);
    b0 = busy_total;
    w0 = write_total;
    r0 = rise_total;
    @(negedge clk);
    cfg_rows = 8'd4;
    cfg_cols = 8'd4;
    cfg_src_base = 12'h300;
    cfg_dst_base = 12'h600;
    pool_run = 1'b1;
    repeat (10) @(negedge clk);
    pool_run = 1'b0;
    repeat (4) @(negedge clk);
    pool_run = 1'b1;
    @(negedge clk);
    pool_run = 1'b0;
    wait_done("t6", 100);
    check("t6_single_op", rise_total - r0, 1);
    check("t6_busy_cycles", busy_total - b0, 25);
    check("t6_writes", write_total - w0, 4);
    check("t6_sb_empty", sb.size(), 0);
    push_model(4, 4, 12'h300, 12'h680, 1000);
    w0 = write_total;
    start_op(4, 4, 12'h300, 12'h680);
    check("t6_rerun_accepted", pool_busy, 1);
    wait_done("t6_rerun", 100);
    check("t6_rerun_ops", rise_total - r0, 2);
    check("t6_rerun_writes", write_total - w0, 4);
    check("t6_rerun_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool_relu_stage.md
Name: pool_relu_stage

Overview:
- Post-processing stage directly downstream of the `project` compute engine.
- Starts after `project` drops `dut_busy`. Reads its 16-bit signed result matrix (row-major) from the output SRAM.
- Applies ReLU and 2x2 stride-2 max pooling, then writes the pooled matrix to a second SRAM.
- Uses the same run/busy handshake as `project`, so the same bench stimulus style drives it.

Parameters:
- ADDR_WIDTH, 12, SRAM address width; all address arithmetic wraps modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 16, sample width, two's complement signed.
- DIM_WIDTH, 8, width of the row/column configuration inputs.

Ports:
- clk  in  1  single clock, rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- pool_run  in  1  start request, sampled only in IDLE.
- pool_busy  out  1  high while an operation is in progress.
- cfg_rows  in  DIM_WIDTH  source matrix rows, latched at start.
- cfg_cols  in  DIM_WIDTH  source matrix columns, latched at start.
- cfg_src_base  in  ADDR_WIDTH  source SRAM base address, latched at start.
- cfg_dst_base  in  ADDR_WIDTH  destination SRAM base address, latched at start.
- pool_sram_read_address  out  ADDR_WIDTH  source SRAM read address.
- sram_pool_read_data  in  DATA_WIDTH  source read data, valid one cycle after its address.
- pool_sram_write_enable  out  1  destination write strobe.
- pool_sram_write_address  out  ADDR_WIDTH  destination write address.
- pool_sram_write_data  out  DATA_WIDTH  pooled value.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `reset_b` is asynchronous and active-low.
- Reset values: every output is 0 and the FSM is in IDLE. Reset asserted mid-operation aborts immediately; no further writes occur, and a new run is needed afterwards.
- Start: in IDLE, `pool_run`=1 at a rising edge latches all cfg_* inputs.
  - `pool_busy` goes high in the next cycle.
  - `pool_run` is ignored while busy; the driver may hold it high until it sees busy.
- Output size: PR = cfg_rows/2 and PC = cfg_cols/2, using floor division. An odd last row or last column is ignored.
- Zero-size operation: if PR=0 or PC=0, the FSM goes IDLE -> DONE with no reads and no writes.
- Element addressing: pooled element (r,c), with r in 0..PR-1 and c in 0..PC-1, is processed in row-major order.
- Read order: the four source reads are issued in the order (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
  - Source address = cfg_src_base + row*cfg_cols + col.
- States:
  - IDLE: wait for `pool_run`.
  - RD0..RD3: one address issued per state. Data for RDk is captured in the following cycle.
  - FIN: data from RD3 is folded in.
  - WR: write enable asserted for exactly one cycle.
    - Write address = cfg_dst_base + r*PC + c.
    - Write data = the accumulated max.
    - Next state is RD0 for the next element, or DONE after the last element.
  - DONE: `pool_busy` drops at the end of this cycle; return to IDLE.
- Accumulator:
  - Initialised to 0 at RD0, so negative values clamp to 0 and ReLU is implicit.
  - Updated as acc = signed_max(acc, data) on each returned sample.
  - Equal values leave acc unchanged.
- Latency: exactly 6 cycles per pooled element. Busy duration = 6*PR*PC + 1 cycles (DONE included).
- Read address when no read is issued: 0.
- Write outputs when write enable is low: address and data outputs are held at 0.
- Address wrap: an address exceeding 2^ADDR_WIDTH-1 wraps silently and raises no error.
- Timing: no combinational path from any input to any output. All outputs are registered.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: accumulator is initialised to 0 (ReLU + max pool, as above).
- Undefined: accumulator is initialised to the most-negative value, -2^(DATA_WIDTH-1), giving pure signed max pooling. Negative results are written unmodified.
- Timing is identical in both builds.

Decomposition:
- Package pool_pkg contains:
  - the state enum (IDLE, RD0, RD1, RD2, RD3, FIN, WR, DONE);
  - the DATA_WIDTH, ADDR_WIDTH and DIM_WIDTH defaults;
  - the ACC_INIT constant, selected by POOL_RELU_EN.
- One sub-module, pool_addr_gen, owns:
  - the r/c counters and the row-base offset row*cfg_cols, maintained by incremental addition with no multiplier;
  - generation of the read and write addresses;
  - a last-element flag.
- The top level keeps the FSM, the accumulator and the registered SRAM outputs.

Test Plan:
- 8x12 matrix (96 results at src 0x000), dst 0x100, values = index-48 -> 24 writes to 0x100..0x117; all negative windows write 0; busy lasts 145 cycles.
- 4x4 with windows {-5,-3,-7,-1} and {1,9,2,9}:
  - POOL_RELU_EN defined -> writes 0 then 9.
  - POOL_RELU_EN undefined -> writes 0xFFFF then 9.
- 5x3 (odd dims) -> PR=2, PC=1, 2 writes; row 4 and column 2 are never read (check the read address trace).
- cfg_rows=0 -> busy high for exactly 1 cycle, no reads and no writes.
- Reset asserted during the 3rd element's RD2 -> all outputs 0 immediately, no further writes. A new run then completes correctly.
- `pool_run` held high for 10 cycles and re-asserted while busy -> exactly one operation; re-run accepted only after busy falls.
